elevator_call_scheduler: RTL and testbench
==========================================

# elevator_call_scheduler

- Latches hall calls and cab selections for a 4-floor car and decides the next move using a collective sweep policy.
- Commands the motion stage (stop/up/down) and asks the door controller to open at each served floor.
- Holds everything during an emergency stop.
- Sits between the floor-position decoder and the motor/door control inside the elevator system.

## Interface
- NUM_FLOORS, 4, number of served floors; pending/request widths equal NUM_FLOORS, floor index width is clog2(NUM_FLOORS)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- hall_req  in  4  hall call buttons, bit i = floor i; a level or pulse of one cycle is enough to latch
- cab_req  in  4  in-car floor selection, same semantics as hall_req
- cur_floor  in  2  encoded floor index from the position decoder
- at_floor  in  1  car aligned with cur_floor
- door_done  in  1  one-cycle pulse from the door controller when the door has closed after service
- emergency  in  1  emergency brake active (level)
- move_cmd  out  2  00 stop, 01 up, 10 down, 11 never driven
- open_req  out  1  one-cycle pulse requesting a door open at cur_floor
- pending  out  4  latched outstanding calls
- dir_up  out  1  current sweep direction, 1 = up
- state_dbg  out  3  current FSM state encoding

## Operation
- **Pending latch**
  - pending <= (pending | hall_req | cab_req) & ~clear_mask.
  - clear_mask = onehot(cur_floor) in the cycle the FSM enters OPEN, and on every cycle spent in OPEN. Calls for the floor being served are absorbed.
- **Helper flags** (from pending): above = any pending bit > cur_floor; below = any pending bit < cur_floor; here = pending[cur_floor].
- **FSM states**: IDLE, UP, DOWN, OPEN, HALT.
- **IDLE** (move_cmd 00)
  - at_floor & here -> OPEN.
  - Else if dir_up: above -> UP, otherwise below -> DOWN.
  - Else if !dir_up: below -> DOWN, otherwise above -> UP.
  - Else stay in IDLE.
  - Entering UP sets dir_up = 1; entering DOWN clears it.
- **UP** (move_cmd 01)
  - at_floor & here -> OPEN.
  - at_floor & !above -> IDLE.
  - Else stay in UP.
- **DOWN** (move_cmd 10): mirror of UP, using below.
- **OPEN** (move_cmd 00)
  - open_req is high only on the first cycle in OPEN.
  - door_done -> IDLE.
- **HALT** (move_cmd 00)
  - Entered from any state when emergency = 1; this has priority over every other transition.
  - pending keeps latching new calls and is not cleared.
  - emergency = 0 -> IDLE.
  - door_done is ignored while in HALT.
- dir_up is held in OPEN, HALT and IDLE-with-no-calls.

## Timing
- **Reset values**: state IDLE, pending 0000, dir_up 1, move_cmd 00, open_req 0, state_dbg = IDLE.
- **Outputs**: all registered (Moore, derived from state).
- **Latency**:
  - Request at edge n -> pending bit visible after edge n+1.
  - IDLE decision at edge n+2 -> move_cmd valid after edge n+2.
  - at_floor & here sampled at edge k -> move_cmd 00 and open_req 1 after edge k.
- **Reversal**: always passes through exactly one IDLE cycle with move_cmd 00. There is no direct UP<->DOWN transition.
- **Boundaries**
  - cur_floor 3 in UP with no call at 3 -> IDLE.
  - cur_floor 0 in DOWN likewise.
  - at_floor = 0 never triggers a stop or direction decision.
- **Simultaneous events**
  - emergency and door_done in the same cycle -> HALT.
  - A request for cur_floor during OPEN is dropped.
  - A request for another floor during OPEN is latched.
- **rst mid-operation**: discards all pending calls and returns to the reset values on the next edge.

## Structure
- **Shared package elevator_pkg** holds:
  - NUM_FLOORS
  - move encodings MOVE_STOP / MOVE_UP / MOVE_DOWN
  - state enum (IDLE, UP, DOWN, OPEN, HALT)
  - floor index width
- **Sub-module call_scan**: purely combinational. Takes pending and cur_floor; produces above, below and here. It is reused by the display/direction logic.
- **Top**: pending register and FSM only.

## Test plan
- **Reset, then single call**: reset; cur_floor 0, at_floor 1, cab_req 0001 for one cycle -> OPEN, open_req pulse; pending back to 0000; after door_done -> IDLE; move_cmd stays 00 throughout.
- **Up-sweep with an intermediate stop**: car at 0; hall_req 1000, then cab_req 0100 while moving -> move_cmd 01.
  - At floor 2: stop, open_req, pending 1000.
  - After door_done: one IDLE cycle, then UP again.
  - At floor 3: OPEN.
- **Reversal**: car at 2 with dir_up 1; pending 0001 only -> one IDLE cycle, then move_cmd 10 and dir_up 0; stop at floor 0.
- **Emergency during UP**: pulse emergency for 4 cycles; hall_req 0010 arrives meanwhile -> move_cmd 00 in HALT; pending includes 0010; after release: IDLE, then resume per policy.
- **Call for the served floor during OPEN**: at floor 1 in OPEN, hall_req 0010 -> not latched; after door_done -> IDLE, with no second open_req.
- **Reset mid-move**: pending 1100 while in UP; assert rst -> after the next edge pending 0000, move_cmd 00, dir_up 1.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call scheduler: floor count, motion
// encodings, FSM state enum and small helpers.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = $clog2(NUM_FLOORS);

    localparam logic [1:0] MOVE_STOP = 2'b00;
    localparam logic [1:0] MOVE_UP   = 2'b01;
    localparam logic [1:0] MOVE_DOWN = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP   = 3'd1,
        DOWN = 3'd2,
        OPEN = 3'd3,
        HALT = 3'd4
    } state_e;

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] one;
        one = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
        return one << f;
    endfunction

    function automatic logic [1:0] move_of(input state_e st);
        logic [1:0] mv;
        case (st)
            UP:      mv = MOVE_UP;
            DOWN:    mv = MOVE_DOWN;
            default: mv = MOVE_STOP;
        endcase
        return mv;
    endfunction

endpackage

// File: rtl/elevator_call_scheduler_call_scan.sv
// Combinational scan of the pending-call vector relative to the car position:
// any call above, any call below, and a call at the current floor.
module call_scan
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic                  above,
    output logic                  below,
    output logic                  here
);

    logic above_s;
    logic below_s;

    // OR-reduce the pending calls on each side of the current floor
    always_comb begin
        above_s = 1'b0;
        below_s = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_s = above_s | (pending[i] & (FLOOR_W'(i) > cur_floor));
            below_s = below_s | (pending[i] & (FLOOR_W'(i) < cur_floor));
        end
    end

    assign above = above_s;
    assign below = below_s;
    assign here  = pending[cur_floor];

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective-sweep call scheduler for a 4-floor car: latches calls, drives
// the motion command and door-open pulse, and freezes on emergency.
module elevator_call_scheduler
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] hall_req,
    input  logic [NUM_FLOORS-1:0] cab_req,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  at_floor,
    input  logic                  door_done,
    input  logic                  emergency,
    output logic [1:0]            move_cmd,
    output logic                  open_req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic [2:0]            state_dbg
);

    state_e                state_r;
    state_e                state_nxt_s;
    logic [NUM_FLOORS-1:0] pending_r;
    logic                  dir_up_r;
    logic [1:0]            move_cmd_r;
    logic                  open_req_r;
    logic [2:0]            state_dbg_r;

    logic                  above_s;
    logic                  below_s;
    logic                  here_s;
    logic [NUM_FLOORS-1:0] clear_mask_s;

    call_scan u_call_scan (
        .pending   (pending_r),
        .cur_floor (cur_floor),
        .above     (above_s),
        .below     (below_s),
        .here      (here_s)
    );

    // Next-state selection; emergency overrides every other transition
    always_comb begin
        state_nxt_s = state_r;
        if (emergency) begin
            state_nxt_s = HALT;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!at_floor) begin
                        state_nxt_s = IDLE;
                    end else if (here_s) begin
                        state_nxt_s = OPEN;
                    end else if (dir_up_r) begin
                        if (above_s) begin
                            state_nxt_s = UP;
                        end else if (below_s) begin
                            state_nxt_s = DOWN;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        if (below_s) begin
                            state_nxt_s = DOWN;
                        end else if (above_s) begin
                            state_nxt_s = UP;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end
                end
                UP: begin
                    if (at_floor && here_s) begin
                        state_nxt_s = OPEN;
                    end else if (at_floor && !above_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = UP;
                    end
                end
                DOWN: begin
                    if (at_floor && here_s) begin
                        state_nxt_s = OPEN;
                    end else if (at_floor && !below_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DOWN;
                    end
                end
                OPEN: begin
                    if (door_done) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = OPEN;
                    end
                end
                HALT:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Absorb calls for the served floor on OPEN entry and throughout OPEN
    always_comb begin
        clear_mask_s = {NUM_FLOORS{1'b0}};
        if ((state_nxt_s == OPEN) || (state_r == OPEN)) begin
            clear_mask_s = floor_onehot(cur_floor);
        end else begin
            clear_mask_s = {NUM_FLOORS{1'b0}};
        end
    end

    // State, call latch and registered Moore outputs (aligned with next state)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pending_r   <= {NUM_FLOORS{1'b0}};
            dir_up_r    <= 1'b1;
            move_cmd_r  <= MOVE_STOP;
            open_req_r  <= 1'b0;
            state_dbg_r <= IDLE;
        end else begin
            state_r     <= state_nxt_s;
            pending_r   <= (pending_r | hall_req | cab_req) & ~clear_mask_s;
            if (state_nxt_s == UP) begin
                dir_up_r <= 1'b1;
            end else if (state_nxt_s == DOWN) begin
                dir_up_r <= 1'b0;
            end else begin
                dir_up_r <= dir_up_r;
            end
            move_cmd_r  <= move_of(state_nxt_s);
            open_req_r  <= (state_nxt_s == OPEN) && (state_r != OPEN);
            state_dbg_r <= state_nxt_s;
        end
    end

    assign move_cmd  = move_cmd_r;
    assign open_req  = open_req_r;
    assign pending   = pending_r;
    assign dir_up    = dir_up_r;
    assign state_dbg = state_dbg_r;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: a table of per-cycle vectors
// followed by hand-written multi-cycle sequences, all with hand-computed results.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hall_req;
    logic [3:0] cab_req;
    logic [1:0] cur_floor;
    logic       at_floor;
    logic       door_done;
    logic       emergency;
    logic [1:0] move_cmd;
    logic       open_req;
    logic [3:0] pending;
    logic       dir_up;
    logic [2:0] state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic [3:0] hall;
        logic [3:0] cab;
        logic [1:0] cur;
        logic       at;
        logic       door;
        logic       em;
        logic [1:0] mv;
        logic       op;
        logic [3:0] pd;
        logic       dir;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[24];

    elevator_call_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .hall_req  (hall_req),
        .cab_req   (cab_req),
        .cur_floor (cur_floor),
        .at_floor  (at_floor),
        .door_done (door_done),
        .emergency (emergency),
        .move_cmd  (move_cmd),
        .open_req  (open_req),
        .pending   (pending),
        .dir_up    (dir_up),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] h, input logic [3:0] c,
                                input logic [1:0] cf, input logic af, input logic dd,
                                input logic em, input logic [1:0] mv, input logic op,
                                input logic [3:0] pd, input logic dir, input logic [2:0] st);
        vec_t v;
        v.rst = r; v.hall = h; v.cab = c; v.cur = cf; v.at = af; v.door = dd; v.em = em;
        v.mv = mv; v.op = op; v.pd = pd; v.dir = dir; v.st = st;
        return v;
    endfunction

    // Drive one cycle of inputs, clock once, compare all outputs
    task automatic step(input string name, input vec_t v);
        logic [10:0] act;
        logic [10:0] exp;
        rst = v.rst; hall_req = v.hall; cab_req = v.cab; cur_floor = v.cur;
        at_floor = v.at; door_done = v.door; emergency = v.em;
        @(posedge clk);
        #1;
        act = {move_cmd, open_req, pending, dir_up, state_dbg};
        exp = {v.mv, v.op, v.pd, v.dir, v.st};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got move=%b open=%b pend=%b dir=%b st=%0d, want move=%b open=%b pend=%b dir=%b st=%0d",
                     name, move_cmd, open_req, pending, dir_up, state_dbg,
                     v.mv, v.op, v.pd, v.dir, v.st);
        end
    endtask

    initial begin
        rst = 1'b1; hall_req = 4'b0; cab_req = 4'b0; cur_floor = 2'd0;
        at_floor = 1'b1; door_done = 1'b0; emergency = 1'b0;
        #2;

        //                rst   hall     cab      cur    at    door  em    mv     op    pend     dir   st
        tbl[0]  = mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 3'd0);
        tbl[1]  = mk(1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0001, 1'b1, 3'd0);
        tbl[2]  = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'b0000, 1'b1, 3'd3);
        tbl[3]  = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 3'd3);
        tbl[4]  = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 3'd0);
        tbl[5]  = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 3'd0);
        tbl[6]  = mk(1'b0, 4'b1000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b1000, 1'b1, 3'd0);
        tbl[7]  = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'b1000, 1'b1, 3'd1);
        tbl[8]  = mk(1'b0, 4'b0000, 4'b0100, 2'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'b1100, 1'b1, 3'd1);
        tbl[9]  = mk(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'b1100, 1'b1, 3'd1);
        tbl[10] = mk(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'b1100, 1'b1, 3'd1);
        tbl[11] = mk(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'b1000, 1'b1, 3'd3);
        tbl[12] = mk(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b1000, 1'b1, 3'd3);
        tbl[13] = mk(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'b1000, 1'b1, 3'd0);
        tbl[14] = mk(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'b1000, 1'b1, 3'd1);
        tbl[15] = mk(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'b1000, 1'b1, 3'd1);
        tbl[16] = mk(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'b0000, 1'b1, 3'd3);
        tbl[17] = mk(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 3'd0);
        tbl[18] = mk(1'b0, 4'b0000, 4'b0001, 2'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0001, 1'b1, 3'd0);
        tbl[19] = mk(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 4'b0001, 1'b0, 3'd2);
        tbl[20] = mk(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 4'b0001, 1'b0, 3'd2);
        tbl[21] = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'b0000, 1'b0, 3'd3);
        tbl[22] = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 3'd0);
        tbl[23] = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 3'd0);

        for (int i = 0; i < 24; i++) begin
            step($sformatf("table[%0d]", i), tbl[i]);
        end

        // Call for the floor being served while the door is open
        step("open_latch",    mk(1'b0, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0010, 1'b0, 3'd0));
        step("open_enter",    mk(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'b0000, 1'b0, 3'd3));
        step("open_drop",     mk(1'b0, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 3'd3));
        step("open_drop_dd",  mk(1'b0, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 3'd0));
        step("open_no_again", mk(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 3'd0));

        // Emergency during UP with a call arriving while halted
        step("em_latch",      mk(1'b0, 4'b1000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b1000, 1'b0, 3'd0));
        step("em_go_up",      mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'b1000, 1'b1, 3'd1));
        step("em_halt",       mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b1000, 1'b1, 3'd4));
        step("em_halt_call",  mk(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b1010, 1'b1, 3'd4));
        step("em_halt_hold",  mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'b1010, 1'b1, 3'd4));
        step("em_halt_door",  mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'b1010, 1'b1, 3'd4));
        step("em_release",    mk(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b1010, 1'b1, 3'd0));
        step("em_resume",     mk(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'b1000, 1'b1, 3'd3));
        step("em_and_door",   mk(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 4'b1000, 1'b1, 3'd4));
        step("em_release2",   mk(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b1000, 1'b1, 3'd0));
        step("em_up_again",   mk(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'b1000, 1'b1, 3'd1));

        // Reset while moving up with calls outstanding
        step("rst_pre",       mk(1'b0, 4'b0000, 4'b0100, 2'd1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'b1100, 1'b1, 3'd1));
        step("rst_mid",       mk(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 3'd0));

        // Top-floor boundary in UP with no call there, then reversal
        step("top_latch",     mk(1'b0, 4'b0000, 4'b0100, 2'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0100, 1'b1, 3'd0));
        step("top_up",        mk(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'b0100, 1'b1, 3'd1));
        step("top_boundary",  mk(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0100, 1'b1, 3'd0));
        step("top_reverse",   mk(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 4'b0100, 1'b0, 3'd2));
        step("top_serve",     mk(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'b0000, 1'b0, 3'd3));
        step("top_done",      mk(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 3'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
